// File: rtl/led_fader_pkg.sv
// rtl/led_fader_pkg.sv - shared fade state type and default parameters for led_fader
package led_fader_pkg;

  typedef enum logic [1:0] {
    FADE_OFF  = 2'd0,
    FADE_RISE = 2'd1,
    FADE_ON   = 2'd2,
    FADE_FALL = 2'd3
  } fade_state_t;

  localparam int DEF_LEVEL_WIDTH = 8;
  localparam int DEF_TICK_CYCLES = 39_062;
  localparam int DEF_STEP        = 1;

endpackage

// File: rtl/led_fader_channel.sv
// rtl/led_fader_channel.sv - one LED channel: fade FSM, saturating level and PWM compare
module led_fader_channel
  import led_fader_pkg::*;
#(
  parameter int LEVEL_WIDTH = DEF_LEVEL_WIDTH,
  parameter int STEP        = DEF_STEP
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_target,
  input  logic                   i_tick,
  input  logic [LEVEL_WIDTH-1:0] i_pwm_cnt,
  output fade_state_t            o_state,
  output logic                   o_led
);

  localparam logic [LEVEL_WIDTH-1:0] MAX_L  = {LEVEL_WIDTH{1'b1}};
  localparam logic [LEVEL_WIDTH:0]   STEP_W = (LEVEL_WIDTH+1)'(STEP);

  logic [LEVEL_WIDTH-1:0] r_level;
  fade_state_t            r_state;
  logic                   r_led;

  logic [LEVEL_WIDTH:0]   w_sum;
  logic [LEVEL_WIDTH:0]   w_diff;
  logic [LEVEL_WIDTH-1:0] w_up;
  logic [LEVEL_WIDTH-1:0] w_dn;
  logic [LEVEL_WIDTH-1:0] w_next_level;
  fade_state_t            w_next_state;

  // Saturating step in the direction of the current target; a reversal on a tick steps the new way
  always_comb begin
    w_sum  = {1'b0, r_level} + STEP_W;
    w_diff = {1'b0, r_level} - STEP_W;
    // The extra top bit flags overflow past MAX on the way up and borrow below 0 on the way down
    w_up   = w_sum[LEVEL_WIDTH]  ? MAX_L : w_sum[LEVEL_WIDTH-1:0];
    w_dn   = w_diff[LEVEL_WIDTH] ? '0    : w_diff[LEVEL_WIDTH-1:0];

    w_next_level = r_level;
    w_next_state = r_state;
    if (i_target && (r_state != FADE_ON)) begin
      if (i_tick) w_next_level = w_up;
      w_next_state = (w_next_level == MAX_L) ? FADE_ON : FADE_RISE;
    end else if (!i_target && (r_state != FADE_OFF)) begin
      if (i_tick) w_next_level = w_dn;
      w_next_state = (w_next_level == '0) ? FADE_OFF : FADE_FALL;
    end
  end

  // State, level and registered PWM output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= '0;
      r_state <= FADE_OFF;
      r_led   <= 1'b0;
    end else begin
      r_level <= w_next_level;
      r_state <= w_next_state;
      r_led   <= (r_level > i_pwm_cnt);
    end
  end

  assign o_state = r_state;
  assign o_led   = r_led;

endmodule

// File: rtl/led_fader.sv
// rtl/led_fader.sv - multi-channel LED fader with shared prescaler and PWM counter
module led_fader
  import led_fader_pkg::*;
#(
  parameter int OUTPUT_WIDTH = 4,
  parameter int LEVEL_WIDTH  = DEF_LEVEL_WIDTH,
  parameter int TICK_CYCLES  = DEF_TICK_CYCLES,
  parameter int STEP         = DEF_STEP
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [OUTPUT_WIDTH-1:0] pattern,
  output logic [OUTPUT_WIDTH-1:0] led,
  output logic                    busy
);

  localparam int PRESC_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PRESC_W-1:0]     PRESC_LAST = PRESC_W'(TICK_CYCLES - 1);
  localparam logic [LEVEL_WIDTH-1:0] PWM_LAST   = LEVEL_WIDTH'((1 << LEVEL_WIDTH) - 2);

  logic [OUTPUT_WIDTH-1:0] r_pattern_q;
  logic [PRESC_W-1:0]      r_presc;
  logic [LEVEL_WIDTH-1:0]  r_pwm_cnt;
  logic                    r_busy;
  logic                    w_tick;
  logic [OUTPUT_WIDTH-1:0] w_active;

  assign w_tick = (r_presc == PRESC_LAST);

  // Input register; every channel decision is made from the registered pattern
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pattern_q <= '0;
    else     r_pattern_q <= pattern;
  end

  // Free-running ramp prescaler, wraps after TICK_CYCLES counts
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + PRESC_W'(1);
  end

  // Shared PWM counter 0..MAX-1, so level MAX is always on and level 0 always off
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       r_pwm_cnt <= '0;
    else if (r_pwm_cnt == PWM_LAST) r_pwm_cnt <= '0;
    else                           r_pwm_cnt <= r_pwm_cnt + LEVEL_WIDTH'(1);
  end

  for (genvar i = 0; i < OUTPUT_WIDTH; i++) begin : g_ch
    fade_state_t w_ch_state;

    led_fader_channel #(
      .LEVEL_WIDTH (LEVEL_WIDTH),
      .STEP        (STEP)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .i_target  (r_pattern_q[i]),
      .i_tick    (w_tick),
      .i_pwm_cnt (r_pwm_cnt),
      .o_state   (w_ch_state),
      .o_led     (led[i])
    );

    assign w_active[i] = (w_ch_state == FADE_RISE) || (w_ch_state == FADE_FALL);
  end

  // Busy flag trails the channel states by one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_busy <= 1'b0;
    else     r_busy <= |w_active;
  end

  assign busy = r_busy;

endmodule

// File: tb/tb_led_fader.sv
// tb/tb_led_fader.sv - scoreboard bench for led_fader
module tb_led_fader;
  import led_fader_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] pattern;
  logic [3:0] pattern_c;
  logic [3:0] led_a, led_b, led_c;
  logic       busy_a, busy_b, busy_c;

  int total = 0;
  int bad   = 0;

  // Expected level sequences; index 0..3 = dut_a channels, 4..7 = dut_b channels
  int exp_q [8][$];
  int prev  [8];
  int mon_cur, mon_exp;

  logic [3:0] lvl_a [4];
  logic [3:0] lvl_b [4];
  logic [1:0] st_a  [4];
  logic [1:0] st_b  [4];
  logic [3:0] lvl_c0;

  always #5 clk = ~clk;

  led_fader #(.OUTPUT_WIDTH(4), .LEVEL_WIDTH(4), .TICK_CYCLES(4), .STEP(4)) dut_a (
    .clk(clk), .rst(rst), .pattern(pattern), .led(led_a), .busy(busy_a));
  led_fader #(.OUTPUT_WIDTH(4), .LEVEL_WIDTH(4), .TICK_CYCLES(4), .STEP(5)) dut_b (
    .clk(clk), .rst(rst), .pattern(pattern), .led(led_b), .busy(busy_b));
  led_fader #(.OUTPUT_WIDTH(4), .LEVEL_WIDTH(4), .TICK_CYCLES(1000), .STEP(5)) dut_c (
    .clk(clk), .rst(rst), .pattern(pattern_c), .led(led_c), .busy(busy_c));

  for (genvar g = 0; g < 4; g++) begin : g_peek
    assign lvl_a[g] = dut_a.g_ch[g].u_ch.r_level;
    assign lvl_b[g] = dut_b.g_ch[g].u_ch.r_level;
    assign st_a[g]  = dut_a.g_ch[g].u_ch.r_state;
    assign st_b[g]  = dut_b.g_ch[g].u_ch.r_state;
  end
  assign lvl_c0 = dut_c.g_ch[0].u_ch.r_level;

  function automatic int lvl_of(input int k);
    return (k < 4) ? int'(lvl_a[k]) : int'(lvl_b[k-4]);
  endfunction

  function automatic int state_of(input int k);
    return (k < 4) ? int'(st_a[k]) : int'(st_b[k-4]);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // STEP=4 instance saturates at the top; STEP=5 instance lands exactly on 15 and 0
  task automatic push_rise(input int k);
    if (k < 4) begin
      exp_q[k].push_back(4); exp_q[k].push_back(8); exp_q[k].push_back(12); exp_q[k].push_back(15);
    end else begin
      exp_q[k].push_back(5); exp_q[k].push_back(10); exp_q[k].push_back(15);
    end
  endtask

  task automatic push_fall(input int k);
    if (k < 4) begin
      exp_q[k].push_back(11); exp_q[k].push_back(7); exp_q[k].push_back(3); exp_q[k].push_back(0);
    end else begin
      exp_q[k].push_back(10); exp_q[k].push_back(5); exp_q[k].push_back(0);
    end
  endtask

  task automatic push_reversal();
    exp_q[0].push_back(4); exp_q[0].push_back(8); exp_q[0].push_back(4); exp_q[0].push_back(0);
    exp_q[4].push_back(5); exp_q[4].push_back(10); exp_q[4].push_back(5); exp_q[4].push_back(0);
  endtask

  task automatic wait_state(input int k, input int st, input int lim);
    int n = 0;
    while (state_of(k) != st && n < lim) begin
      step();
      n++;
    end
    check($sformatf("wait_state[%0d]", k), state_of(k), st);
  endtask

  task automatic wait_level(input int k, input int v, input int lim);
    int n = 0;
    while (lvl_of(k) != v && n < lim) begin
      step();
      n++;
    end
    check($sformatf("wait_level[%0d]", k), lvl_of(k), v);
  endtask

  task automatic count_led(input int which, input int ncyc, output int n);
    n = 0;
    for (int i = 0; i < ncyc; i++) begin
      step();
      case (which)
        0:       n += int'(led_a[0]);
        1:       n += int'(led_b[0]);
        2:       n += int'(led_c[0]);
        default: n += int'(led_a[0] | led_a[2]);
      endcase
    end
  endtask

  // Monitor: every level change outside reset is popped against the scoreboard
  always @(negedge clk) begin
    for (int k = 0; k < 8; k++) begin
      mon_cur = lvl_of(k);
      if (!rst && mon_cur != prev[k]) begin
        if (exp_q[k].size() == 0) begin
          check($sformatf("unexpected_level[%0d]", k), mon_cur, prev[k]);
        end else begin
          mon_exp = exp_q[k].pop_front();
          check($sformatf("level[%0d]", k), mon_cur, mon_exp);
        end
      end
      prev[k] = mon_cur;
    end
  end

  initial begin
    #300_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int left;
    rst = 1'b1; pattern = 4'b0000; pattern_c = 4'b0000;
    for (int k = 0; k < 8; k++) prev[k] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_led_a", int'(led_a), 0);
    check("rst_led_b", int'(led_b), 0);
    check("rst_busy_a", int'(busy_a), 0);
    check("rst_state_a0", int'(st_a[0]), int'(FADE_OFF));
    rst = 1'b0;

    // Rise with saturation
    push_rise(0); push_rise(4);
    step(); pattern = 4'b0001;
    step(); check("rise_lag1", int'(st_a[0]), int'(FADE_OFF));
    step(); check("rise_lag2", int'(st_a[0]), int'(FADE_RISE));
    wait_state(4, int'(FADE_ON), 40);
    check("busy_at_on_b", int'(busy_b), 1);
    step(); check("busy_drop_b", int'(busy_b), 0);
    wait_state(0, int'(FADE_ON), 40);
    check("busy_at_on_a", int'(busy_a), 1);
    step(); check("busy_drop_a", int'(busy_a), 0);
    count_led(0, 20, n); check("on_led_a", n, 20);
    count_led(1, 20, n); check("on_led_b", n, 20);

    // Fall back to off
    push_fall(0); push_fall(4);
    pattern = 4'b0000;
    wait_state(4, int'(FADE_OFF), 60);
    wait_state(0, int'(FADE_OFF), 60);
    step(); check("off_busy_a", int'(busy_a), 0);
    check("off_busy_b", int'(busy_b), 0);
    count_led(0, 20, n); check("off_led_a", n, 0);

    // Reversal between ticks at level 8
    push_reversal();
    pattern = 4'b0001;
    wait_level(0, 8, 60);
    pattern = 4'b0000;
    step(); check("rev_still_rise", int'(st_a[0]), int'(FADE_RISE));
    step(); check("rev_fall", int'(st_a[0]), int'(FADE_FALL));
    check("rev_hold_level", int'(lvl_a[0]), 8);
    wait_state(0, int'(FADE_OFF), 60);
    wait_state(4, int'(FADE_OFF), 60);

    // Reversal landing on the tick cycle itself
    push_reversal();
    pattern = 4'b0001;
    wait_level(0, 8, 60);
    step();
    step(); pattern = 4'b0000;
    step(); check("tick_rev_pre", int'(st_a[0]), int'(FADE_RISE));
    step(); check("tick_rev_state", int'(st_a[0]), int'(FADE_FALL));
    check("tick_rev_level", int'(lvl_a[0]), 4);
    wait_state(0, int'(FADE_OFF), 60);
    wait_state(4, int'(FADE_OFF), 60);

    // Independent channels, then simultaneous reversal of all four
    push_rise(1); push_rise(3); push_rise(5); push_rise(7);
    pattern = 4'b1010;
    count_led(3, 10, n); check("idle_led_a02", n, 0);
    wait_state(1, int'(FADE_ON), 60);
    wait_state(3, int'(FADE_ON), 60);
    wait_state(7, int'(FADE_ON), 60);
    check("idle_state_a0", int'(st_a[0]), int'(FADE_OFF));
    check("idle_state_a2", int'(st_a[2]), int'(FADE_OFF));
    push_fall(1); push_fall(3); push_fall(5); push_fall(7);
    push_rise(0); push_rise(2); push_rise(4); push_rise(6);
    pattern = 4'b0101;
    wait_state(0, int'(FADE_ON), 60);
    wait_state(2, int'(FADE_ON), 60);
    wait_state(1, int'(FADE_OFF), 60);
    wait_state(3, int'(FADE_OFF), 60);
    wait_state(5, int'(FADE_OFF), 60);
    step(); step();
    check("swap_led_a", int'(led_a), 4'b0101);
    check("swap_led_b", int'(led_b), 4'b0101);

    // PWM duty at level 5 on the slow instance
    pattern_c = 4'b0001;
    begin
      int m = 0;
      while (lvl_c0 != 4'd5 && m < 1100) begin step(); m++; end
    end
    check("duty_level", int'(lvl_c0), 5);
    step(); step();
    count_led(2, 15, n); check("duty_high_cycles", n, 5);

    // Reset in the middle of a ramp
    exp_q[1].push_back(4); exp_q[1].push_back(8);
    exp_q[3].push_back(4); exp_q[3].push_back(8);
    exp_q[5].push_back(5); exp_q[5].push_back(10);
    exp_q[7].push_back(5); exp_q[7].push_back(10);
    pattern = 4'b1111;
    wait_level(1, 8, 60);
    @(negedge clk); #1;
    check("pre_rst_busy", int'(busy_a), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_led_a", int'(led_a), 0);
    check("mid_rst_busy_a", int'(busy_a), 0);
    check("mid_rst_busy_b", int'(busy_b), 0);
    check("mid_rst_lvl_a", int'(lvl_a[0]) + int'(lvl_a[1]) + int'(lvl_a[2]) + int'(lvl_a[3]), 0);
    for (int k = 0; k < 8; k++) push_rise(k);
    step(); step();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) wait_state(k, int'(FADE_ON), 80);
    step(); step();
    check("final_led_a", int'(led_a), 4'b1111);
    check("final_busy_a", int'(busy_a), 0);

    step();
    left = 0;
    for (int k = 0; k < 8; k++) left += exp_q[k].size();
    check("queue_drained", left, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
